// File: rtl/instbuffer_pkg.sv
// Package for the instruction buffer.
// Holds the instruction bus width/type and helpers that decode the fetch
// valid mask and the issue-stage pop request into entry counts (0..2).
`include "cpu.vh"

package instbuffer_pkg;

   localparam int INST_BUS_W = 131;

   typedef logic [INST_BUS_W-1:0] inst_bus_t;

   // Entries offered by fetch. 2'b10 (inst2 without inst1) is illegal and
   // contributes nothing.
   function automatic logic [1:0] fetch_push_count(input logic [1:0] fetch_valid);
      logic [1:0] cnt;
      case (fetch_valid)
         2'b01:   cnt = 2'd1;
         2'b11:   cnt = 2'd2;
         default: cnt = 2'd0;
      endcase
      return cnt;
   endfunction

   // Entries requested by issue. The unused encoding 2'b11 pops nothing.
   function automatic logic [1:0] issue_pop_request(input logic [1:0] issue_mode);
      logic [1:0] cnt;
      case (issue_mode)
         `SingleIssue: cnt = 2'd1;
         `DoubleIssue: cnt = 2'd2;
         default:      cnt = 2'd0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/cpu.vh
// Shared CPU-wide encodings for the issue-stage / instruction-buffer handshake.
//   issue_mode  : NoIssue / SingleIssue / DoubleIssue (2'b11 is unused)
//   inst count  : HaveNoInst / HaveOneInst / HaveTwoInst (two or more held)
`ifndef CPU_VH
`define CPU_VH

`define NoIssue      2'b00
`define SingleIssue  2'b01
`define DoubleIssue  2'b10

`define HaveNoInst   2'b00
`define HaveOneInst  2'b01
`define HaveTwoInst  2'b10

`endif

// File: rtl/instbuffer_mem.sv
// Storage array for the instruction buffer: DEPTH x 131 bits.
// Ports:
//   clk                   - write clock
//   we1/waddr1/wdata1     - write port 1 (entry at tail)
//   we2/waddr2/wdata2     - write port 2 (entry at tail+1)
//   raddr1/rdata1         - asynchronous read port 1 (head)
//   raddr2/rdata2         - asynchronous read port 2 (head+1)
// Contents are never cleared; validity is tracked by the owner's occupancy.
`include "cpu.vh"

module instbuffer_mem
   import instbuffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we1,
   input  logic [AW-1:0] waddr1,
   input  inst_bus_t     wdata1,
   input  logic          we2,
   input  logic [AW-1:0] waddr2,
   input  inst_bus_t     wdata2,
   input  logic [AW-1:0] raddr1,
   output inst_bus_t     rdata1,
   input  logic [AW-1:0] raddr2,
   output inst_bus_t     rdata2
);

   inst_bus_t mem [DEPTH];

   // The two write addresses are always tail and tail+1, so they never collide.
   always_ff @(posedge clk) begin
      if (we1) mem[waddr1] <= wdata1;
      if (we2) mem[waddr2] <= wdata2;
   end

   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];

endmodule

// File: rtl/instbuffer.sv
// Instruction buffer between fetch and issue: a circular FIFO that accepts
// up to two instructions per cycle and releases up to two per cycle.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   branch_flag_i         - flush: drop all held entries next cycle
//   fetch_valid_i         - bit0 inst1 present, bit1 inst2 present
//   fetch_inst1_bus_i     - first fetched instruction
//   fetch_inst2_bus_i     - second fetched instruction
//   issue_mode_i          - NoIssue / SingleIssue / DoubleIssue pop request
//   instbuffer_count_o    - HaveNoInst / HaveOneInst / HaveTwoInst
//   inst1_bus_o           - entry at head (0 when empty)
//   inst2_bus_o           - entry at head+1 (0 when fewer than two held)
//   instbuffer_full_o     - fewer than two free slots; pushes are ignored
//   perf_empty_cycles_o   - (INSTBUFFER_PERF_EN only) cycles spent empty
// Handshake: fetch may offer entries every cycle; they are taken only when
// instbuffer_full_o is low. Issue takes entries shown on inst*_bus_o in the
// same cycle it asserts issue_mode_i; pops beyond occupancy are clamped.
// Optional feature macro: INSTBUFFER_PERF_EN.
`include "cpu.vh"

module instbuffer
   import instbuffer_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_flag_i,
   input  logic [1:0]  fetch_valid_i,
   input  inst_bus_t   fetch_inst1_bus_i,
   input  inst_bus_t   fetch_inst2_bus_i,
   input  logic [1:0]  issue_mode_i,
   output logic [1:0]  instbuffer_count_o,
   output inst_bus_t   inst1_bus_o,
   output inst_bus_t   inst2_bus_o,
   output logic        instbuffer_full_o
`ifdef INSTBUFFER_PERF_EN
   ,
   output logic [31:0] perf_empty_cycles_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_next;

   logic       full;
   logic [1:0] push_cnt;
   logic [1:0] pop_req;
   logic [1:0] pop_cnt;
   logic       accept_we;

   inst_bus_t rdata1;
   inst_bus_t rdata2;

   always_comb begin
      full     = (OCC_W'(DEPTH) - occ) < OCC_W'(2);
      push_cnt = full ? 2'd0 : fetch_push_count(fetch_valid_i);
      pop_req  = issue_pop_request(issue_mode_i);
      // Occupancy below the request can only be 0 or 1 here.
      pop_cnt  = (OCC_W'(pop_req) > occ) ? occ[1:0] : pop_req;
      occ_next = occ - OCC_W'(pop_cnt) + OCC_W'(push_cnt);
   end

   // Writes in a reset or flush cycle would be invisible anyway; suppressing
   // them keeps storage unchanged by abandoned pushes.
   assign accept_we = !rst && !branch_flag_i;

   instbuffer_mem #(
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clk    (clk),
      .we1    (accept_we && (push_cnt != 2'd0)),
      .waddr1 (tail),
      .wdata1 (fetch_inst1_bus_i),
      .we2    (accept_we && (push_cnt == 2'd2)),
      .waddr2 (tail + PTR_W'(1)),
      .wdata2 (fetch_inst2_bus_i),
      .raddr1 (head),
      .rdata1 (rdata1),
      .raddr2 (head + PTR_W'(1)),
      .rdata2 (rdata2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (branch_flag_i) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         head <= head + PTR_W'(pop_cnt);
         tail <= tail + PTR_W'(push_cnt);
         occ  <= occ_next;
      end
   end

   always_comb begin
      if (occ == '0)               instbuffer_count_o = `HaveNoInst;
      else if (occ == OCC_W'(1))   instbuffer_count_o = `HaveOneInst;
      else                         instbuffer_count_o = `HaveTwoInst;
   end

   assign inst1_bus_o       = (occ != '0)        ? rdata1 : '0;
   assign inst2_bus_o       = (occ >= OCC_W'(2)) ? rdata2 : '0;
   assign instbuffer_full_o = full;

`ifdef INSTBUFFER_PERF_EN
   // Counts empty cycles based on the registered occupancy of that cycle.
   always_ff @(posedge clk) begin
      if (rst)             perf_empty_cycles_o <= '0;
      else if (occ == '0)  perf_empty_cycles_o <= perf_empty_cycles_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_instbuffer.sv
module tb_instbuffer;

   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         branch_flag;
   logic [1:0]   fetch_valid;
   logic [130:0] fetch_inst1;
   logic [130:0] fetch_inst2;
   logic [1:0]   issue_mode;
   logic [1:0]   count;
   logic [130:0] inst1;
   logic [130:0] inst2;
   logic         full;
`ifdef INSTBUFFER_PERF_EN
   logic [31:0]  perf_empty;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit check_en  = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   instbuffer #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .branch_flag_i      (branch_flag),
      .fetch_valid_i      (fetch_valid),
      .fetch_inst1_bus_i  (fetch_inst1),
      .fetch_inst2_bus_i  (fetch_inst2),
      .issue_mode_i       (issue_mode),
      .instbuffer_count_o (count),
      .inst1_bus_o        (inst1),
      .inst2_bus_o        (inst2),
      .instbuffer_full_o  (full)
`ifdef INSTBUFFER_PERF_EN
      ,
      .perf_empty_cycles_o (perf_empty)
`endif
   );

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [130:0] act, input logic [130:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model (queue of held instructions) ----------------
   logic [130:0] model_q[$];
   logic [31:0]  model_perf = '0;

   always @(posedge clk) begin
      int pops;
      bit was_full;
      if (rst) begin
         model_q.delete();
         model_perf = '0;
      end else begin
         if (model_q.size() == 0) model_perf = model_perf + 32'd1;
         if (branch_flag) begin
            model_q.delete();
         end else begin
            was_full = (DEPTH - model_q.size()) < 2;
            pops = (issue_mode == 2'b01) ? 1 : (issue_mode == 2'b10) ? 2 : 0;
            if (pops > model_q.size()) pops = model_q.size();
            for (int i = 0; i < pops; i++) void'(model_q.pop_front());
            if (!was_full) begin
               if (fetch_valid == 2'b01 || fetch_valid == 2'b11) model_q.push_back(fetch_inst1);
               if (fetch_valid == 2'b11) model_q.push_back(fetch_inst2);
            end
         end
      end
   end

   // Compare on the falling edge, when registered state is settled.
   always @(negedge clk) begin
      logic [1:0]   e_cnt;
      logic [130:0] e_i1, e_i2;
      if (check_en) begin
         e_cnt = (model_q.size() == 0) ? 2'b00 : (model_q.size() == 1) ? 2'b01 : 2'b10;
         e_i1  = (model_q.size() > 0) ? model_q[0] : '0;
         e_i2  = (model_q.size() > 1) ? model_q[1] : '0;
         check("model_count", 131'(count), 131'(e_cnt));
         check("model_inst1", inst1, e_i1);
         check("model_inst2", inst2, e_i2);
         check("model_full", 131'(full), 131'((DEPTH - model_q.size()) < 2));
`ifdef INSTBUFFER_PERF_EN
         check("model_perf", 131'(perf_empty), 131'(model_perf));
`endif
      end
   end

   // ---------------- driver ----------------
   function automatic logic [130:0] mk(input int k);
      return {35'(k) + 35'h400000000, 32'(k * 3 + 1), ~32'(k), 32'(k) ^ 32'h5a5a5a5a};
   endfunction

   task automatic cyc(input logic [1:0] v, input logic [130:0] a, input logic [130:0] b,
                      input logic [1:0] m, input logic brf, input logic rs);
      fetch_valid = v;
      fetch_inst1 = a;
      fetch_inst2 = b;
      issue_mode  = m;
      branch_flag = brf;
      rst         = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   logic [130:0] c_val, d_val, a_val, b_val;

   initial begin
      c_val = mk(900);
      d_val = mk(901);
      a_val = mk(500);
      b_val = mk(501);
      rst = 1'b1; branch_flag = 1'b0; fetch_valid = '0; fetch_inst1 = '0;
      fetch_inst2 = '0; issue_mode = '0;

      cyc(2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
      check_en = 1'b1;
      cyc(2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
      check("rst_count", 131'(count), 131'(2'b00));
      check("rst_inst1", inst1, '0);
      check("rst_inst2", inst2, '0);
      check("rst_full", 131'(full), 131'(1'b0));
`ifdef INSTBUFFER_PERF_EN
      check("rst_perf", 131'(perf_empty), 131'(0));
      idle();
      check("perf_1", 131'(perf_empty), 131'(1));
`endif

      // Double push A,B visible next cycle.
      cyc(2'b11, a_val, b_val, 2'b00, 1'b0, 1'b0);
      check("ab_count", 131'(count), 131'(2'b10));
      check("ab_inst1", inst1, a_val);
      check("ab_inst2", inst2, b_val);
      check("ab_full", 131'(full), 131'(1'b0));

      // Illegal fetch mask 2'b10 and issue mode 2'b11 do nothing.
      cyc(2'b10, c_val, d_val, 2'b11, 1'b0, 1'b0);
      check("illegal_inst1", inst1, a_val);
      check("illegal_inst2", inst2, b_val);

      // Flush, then fill with 8 double pushes.
      cyc(2'b00, '0, '0, 2'b00, 1'b1, 1'b0);
      check("flush_count", 131'(count), 131'(2'b00));
      for (int k = 0; k < 8; k++) cyc(2'b11, mk(2 * k), mk(2 * k + 1), 2'b00, 1'b0, 1'b0);
      check("fill_full", 131'(full), 131'(1'b1));
      check("fill_inst1", inst1, mk(0));
      check("fill_inst2", inst2, mk(1));
      cyc(2'b11, c_val, d_val, 2'b00, 1'b0, 1'b0);
      cyc(2'b11, c_val, d_val, 2'b00, 1'b0, 1'b0);
      check("full_hold_inst1", inst1, mk(0));
      cyc(2'b00, '0, '0, 2'b01, 1'b0, 1'b0);           // occupancy 15
      check("occ15_full", 131'(full), 131'(1'b1));
      cyc(2'b11, c_val, d_val, 2'b00, 1'b0, 1'b0);     // ignored at 15
      check("occ15_inst1", inst1, mk(1));
      cyc(2'b11, c_val, d_val, 2'b01, 1'b0, 1'b0);     // pop only -> 14
      check("occ14_full", 131'(full), 131'(1'b0));
      check("occ14_inst1", inst1, mk(2));

      // Drain to one entry, then over-pop with DoubleIssue.
      for (int k = 0; k < 6; k++) cyc(2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
      cyc(2'b00, '0, '0, 2'b01, 1'b0, 1'b0);
      check("occ1_count", 131'(count), 131'(2'b01));
      check("occ1_inst1", inst1, mk(15));
      check("occ1_inst2", inst2, '0);
      cyc(2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
      check("overpop_count", 131'(count), 131'(2'b00));
      check("overpop_inst1", inst1, '0);
      cyc(2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
      check("empty_pop_full", 131'(full), 131'(1'b0));

      // Occupancy 3, then simultaneous single pop and double push across wrap.
      cyc(2'b11, mk(200), mk(201), 2'b00, 1'b0, 1'b0);
      cyc(2'b01, mk(202), c_val, 2'b00, 1'b0, 1'b0);
      cyc(2'b11, mk(203), mk(204), 2'b01, 1'b0, 1'b0);
      check("wrap_inst1", inst1, mk(201));
      check("wrap_inst2", inst2, mk(202));
      for (int i = 0; i < 10; i++) cyc(2'b11, mk(300 + 2 * i), mk(301 + 2 * i), 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cyc(2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
      check("wrap_drained", 131'(count), 131'(2'b00));

      // Flush at occupancy 6 with a concurrent push and DoubleIssue.
      for (int i = 0; i < 3; i++) cyc(2'b11, mk(400 + 2 * i), mk(401 + 2 * i), 2'b00, 1'b0, 1'b0);
      cyc(2'b11, c_val, d_val, 2'b10, 1'b1, 1'b0);
      check("flush6_count", 131'(count), 131'(2'b00));
      check("flush6_inst1", inst1, '0);
      check("flush6_inst2", inst2, '0);
      cyc(2'b01, mk(450), c_val, 2'b00, 1'b0, 1'b0);
      check("post_flush_inst1", inst1, mk(450));

      // Reset together with flush and push.
      cyc(2'b11, mk(460), mk(461), 2'b00, 1'b0, 1'b0);
      cyc(2'b11, c_val, d_val, 2'b01, 1'b1, 1'b1);
      check("rst2_count", 131'(count), 131'(2'b00));
      check("rst2_inst1", inst1, '0);
      check("rst2_full", 131'(full), 131'(1'b0));
`ifdef INSTBUFFER_PERF_EN
      check("rst2_perf", 131'(perf_empty), 131'(0));
      idle();
      check("rst2_perf_1", 131'(perf_empty), 131'(1));
      idle();
      check("rst2_perf_2", 131'(perf_empty), 131'(2));
`endif
      idle();
      idle();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
